mor1kx_ticktimer_mc: RTL and testbench

Multi-channel tick timer unit for mor1kx-family cores on the SPR bus. It holds NUM_CHANNELS independent TTMR/TTCR pairs and one shared prescaler. Each channel raises its own interrupt line. A debug stall input freezes time. Accesses are acknowledged with a registered one-cycle handshake so that the block can sit behind a pipelined SPR decoder.

---
 rtl/mor1kx_ticktimer_mc.sv | 153 +++++++++++++++
 tb/tb_mor1kx_ticktimer_mc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_ticktimer_mc.sv
// Multi-channel tick timer for the SPR bus: NUM_CHANNELS TTMR/TTCR pairs sharing one
// prescaler, per-channel interrupts, debug-stall freeze and a registered one-cycle ack.
module mor1kx_ticktimer_mc #(
    parameter int NUM_CHANNELS   = 4,
    parameter int MATCH_WIDTH    = 28,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         du_stall_i,
    input  logic                         spr_access_i,
    input  logic                         spr_we_i,
    input  logic [15:0]                  spr_addr_i,
    input  logic [31:0]                  spr_dat_i,
    output logic                         spr_bus_ack,
    output logic [31:0]                  spr_dat_o,
    output logic [NUM_CHANNELS-1:0]      irq_o,
    output logic [32*NUM_CHANNELS-1:0]   spr_ttmr_o,
    output logic [32*NUM_CHANNELS-1:0]   spr_ttcr_o
);

    localparam int OFF_W = 11;
    localparam logic [OFF_W-1:0] PRESC_OFF = OFF_W'(2 * NUM_CHANNELS);

    logic                         r_ack;
    logic [31:0]                  r_dat;
    logic [PRESCALE_WIDTH-1:0]    r_presc;
    logic [PRESCALE_WIDTH-1:0]    r_pcnt;

    logic                         w_accept;
    logic [OFF_W-1:0]             w_off;
    logic                         w_wr_presc;
    logic                         w_tick;
    logic [31:0]                  w_rdata;
    logic                         w_unused_addr;
    logic [NUM_CHANNELS-1:0][31:0] w_ttmr;
    logic [NUM_CHANNELS-1:0][31:0] w_ttcr;

    // A new access is taken only while the previous ack is not showing.
    assign w_accept      = spr_access_i & ~r_ack;
    assign w_off         = spr_addr_i[OFF_W-1:0];
    assign w_unused_addr = ^spr_addr_i[15:OFF_W];
    assign w_wr_presc    = w_accept & spr_we_i & (w_off == PRESC_OFF);
    assign w_tick        = (r_pcnt == r_presc) & ~du_stall_i;

    assign spr_bus_ack = r_ack;
    assign spr_dat_o   = r_dat;
    assign spr_ttmr_o  = w_ttmr;
    assign spr_ttcr_o  = w_ttcr;

    // Shared prescaler: reload register and free-running count, frozen by debug stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_pcnt  <= '0;
        end else if (w_wr_presc) begin
            r_presc <= spr_dat_i[PRESCALE_WIDTH-1:0];
            r_pcnt  <= '0;
        end else if (!du_stall_i) begin
            if (r_pcnt == r_presc) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PRESCALE_WIDTH'(1);
            end
        end
    end

    // Read mux; unmapped offsets fall through as zero.
    always_comb begin
        w_rdata = 32'd0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_rdata = w_rdata
                    | ({32{w_off == OFF_W'(2 * c)}}     & w_ttmr[c])
                    | ({32{w_off == OFF_W'(2 * c + 1)}} & w_ttcr[c]);
        end
        w_rdata = w_rdata | ({32{w_off == PRESC_OFF}} & 32'(r_presc));
    end

    // Bus handshake: ack and read data live for exactly one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack <= 1'b0;
            r_dat <= 32'd0;
        end else begin
            r_ack <= w_accept;
            r_dat <= (w_accept & ~spr_we_i) ? w_rdata : 32'd0;
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [31:0] r_ttmr;
        logic [31:0] r_ttcr;
        logic        w_wr_ttmr;
        logic        w_wr_ttcr;
        logic        w_match;
        logic        w_clr;
        logic        w_inc;

        assign w_wr_ttmr = w_accept & spr_we_i & (w_off == OFF_W'(2 * c));
        assign w_wr_ttcr = w_accept & spr_we_i & (w_off == OFF_W'(2 * c + 1));
        assign w_match   = (r_ttcr[MATCH_WIDTH-1:0] == r_ttmr[MATCH_WIDTH-1:0]);
        assign w_ttmr[c] = r_ttmr;
        assign w_ttcr[c] = r_ttcr;
        assign irq_o[c]  = r_ttmr[28] & r_ttmr[29];

        // Mode decode into clear/increment requests for this tick.
        always_comb begin
            w_clr = 1'b0;
            w_inc = 1'b0;
            case (r_ttmr[31:30])
                2'b01: begin
                    w_clr = w_tick & w_match;
                    w_inc = w_tick & ~w_match;
                end
                2'b10: begin
                    w_inc = w_tick & ~w_match;
                end
                2'b11: begin
                    w_inc = w_tick;
                end
                default: begin
                    w_clr = 1'b0;
                    w_inc = 1'b0;
                end
            endcase
        end

        // Counter: software write beats match-clear beats increment.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ttcr <= 32'd0;
            end else if (w_wr_ttcr) begin
                r_ttcr <= spr_dat_i;
            end else if (w_clr) begin
                r_ttcr <= 32'd0;
            end else if (w_inc) begin
                r_ttcr <= r_ttcr + 32'd1;
            end
        end

        // Mode register: software write wins; otherwise a live match with IE sets sticky IP.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ttmr <= 32'd0;
            end else if (w_wr_ttmr) begin
                r_ttmr <= spr_dat_i;
            end else if (w_match & r_ttmr[29]) begin
                r_ttmr[28] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mor1kx_ticktimer_mc.sv
// Scoreboard bench for mor1kx_ticktimer_mc: reads push expected data, a negedge monitor
// pops and compares on every ack; a few state checks are taken directly from the outputs.
module tb_mor1kx_ticktimer_mc;

    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              du_stall_i;
    logic              spr_access_i;
    logic              spr_we_i;
    logic [15:0]       spr_addr_i;
    logic [31:0]       spr_dat_i;
    logic              spr_bus_ack;
    logic [31:0]       spr_dat_o;
    logic [NCH-1:0]    irq_o;
    logic [32*NCH-1:0] spr_ttmr_o;
    logic [32*NCH-1:0] spr_ttcr_o;

    typedef struct packed {
        logic        is_read;
        logic [15:0] addr;
        logic [31:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_ack = 1'b0;

    mor1kx_ticktimer_mc #(.NUM_CHANNELS(NCH), .MATCH_WIDTH(28), .PRESCALE_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .du_stall_i   (du_stall_i),
        .spr_access_i (spr_access_i),
        .spr_we_i     (spr_we_i),
        .spr_addr_i   (spr_addr_i),
        .spr_dat_i    (spr_dat_i),
        .spr_bus_ack  (spr_bus_ack),
        .spr_dat_o    (spr_dat_o),
        .irq_o        (irq_o),
        .spr_ttmr_o   (spr_ttmr_o),
        .spr_ttcr_o   (spr_ttcr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack must be single-cycle and match the oldest outstanding access.
    always @(negedge clk) begin
        if (spr_bus_ack === 1'b1) begin
            check("ack_one_cycle", {31'd0, prev_ack}, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.is_read) begin
                    check($sformatf("read_off_%0d", e.addr), spr_dat_o, e.exp);
                end
            end
        end else if (!rst) begin
            check("dat_zero_no_ack", spr_dat_o, 32'd0);
        end
        prev_ack = spr_bus_ack;
    end

    task automatic bus_acc(input logic we, input logic [15:0] a, input logic [31:0] d,
                           input logic [31:0] exp, input logic run);
        @(negedge clk);
        spr_access_i = 1'b1;
        spr_we_i     = we;
        spr_addr_i   = a;
        spr_dat_i    = d;
        if (run) du_stall_i = 1'b0;
        sb_q.push_back('{is_read: ~we, addr: a, exp: exp});
        @(negedge clk);
        spr_access_i = 1'b0;
        spr_we_i     = 1'b0;
        du_stall_i   = 1'b1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        bus_acc(1'b1, a, d, 32'd0, 1'b0);
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] exp);
        bus_acc(1'b0, a, 32'd0, exp, 1'b0);
    endtask

    // Release the stall for exactly k rising edges.
    task automatic run(input int k);
        @(negedge clk);
        du_stall_i = 1'b0;
        repeat (k) @(negedge clk);
        du_stall_i = 1'b1;
    endtask

    initial begin
        rst = 1'b1; du_stall_i = 1'b1; spr_access_i = 1'b0; spr_we_i = 1'b0;
        spr_addr_i = 16'd0; spr_dat_i = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, spr_bus_ack}, 32'd0);
        check("rst_irq", {28'd0, irq_o}, 32'd0);
        check("rst_ttcr0", spr_ttcr_o[31:0], 32'd0);
        check("rst_ttmr3", spr_ttmr_o[127:96], 32'd0);
        rst = 1'b0;

        // Every mapped and unmapped offset reads zero out of reset.
        for (int a = 0; a < 10; a++) rd(16'(a), 32'd0);

        // Channel 0, mode 01 restart at 5 with interrupt enable.
        wr(16'd8, 32'd0);
        wr(16'd1, 32'd0);
        wr(16'd0, 32'h6000_0005);
        run(5);
        rd(16'd1, 32'd5);
        rd(16'd0, 32'h7000_0005);
        check("irq0_set", {31'd0, irq_o[0]}, 32'd1);
        run(1);
        rd(16'd1, 32'd0);
        run(7);
        rd(16'd1, 32'd1);
        check("irq0_sticky", {31'd0, irq_o[0]}, 32'd1);
        wr(16'd0, 32'h6000_0005);
        rd(16'd0, 32'h6000_0005);
        check("irq0_cleared", {31'd0, irq_o[0]}, 32'd0);

        // Channel 1, mode 10 stop-at-match with prescale 3 and no IE.
        wr(16'd0, 32'd0);
        wr(16'd8, 32'd3);
        wr(16'd2, 32'h8000_0002);
        wr(16'd3, 32'd0);
        rd(16'd8, 32'd3);
        run(6);
        rd(16'd3, 32'd1);
        run(5);
        rd(16'd3, 32'd2);
        run(8);
        rd(16'd3, 32'd2);
        rd(16'd2, 32'h8000_0002);
        check("irq1_quiet", {31'd0, irq_o[1]}, 32'd0);

        // Channel 2, mode 11 wraps through 0xFFFFFFFF.
        wr(16'd4, 32'hC000_0000);
        wr(16'd5, 32'hFFFF_FFFE);
        wr(16'd8, 32'd0);
        run(1);
        rd(16'd5, 32'hFFFF_FFFF);
        run(1);
        rd(16'd5, 32'h0000_0000);
        run(1);
        rd(16'd5, 32'h0000_0001);
        rd(16'd4, 32'hC000_0000);
        rd(16'd3, 32'd2);
        rd(16'd1, 32'd1);

        // Stall keeps the prescaler phase: prescale 2, ticks land on every third edge.
        wr(16'd8, 32'd2);
        wr(16'd1, 32'd0);
        wr(16'd0, 32'h4FFF_FFFF);
        run(4);
        repeat (10) @(negedge clk);
        check("stall_hold", spr_ttcr_o[31:0], 32'd1);
        run(1);
        check("phase_no_tick", spr_ttcr_o[31:0], 32'd1);
        run(1);
        check("phase_tick", spr_ttcr_o[31:0], 32'd2);
        rd(16'd1, 32'd2);

        // Channel 3: TTCR write on the same edge as a match-clear wins.
        wr(16'd8, 32'd0);
        wr(16'd6, 32'h4000_0003);
        wr(16'd7, 32'd3);
        bus_acc(1'b1, 16'd7, 32'h0000_0055, 32'd0, 1'b1);
        rd(16'd7, 32'h0000_0055);
        rd(16'd6, 32'h4000_0003);

        // IP cleared by software while match & IE persist, re-set one cycle later.
        wr(16'd0, 32'h2000_0002);
        wr(16'd1, 32'd2);
        rd(16'd0, 32'h3000_0002);
        check("irq0_match", {31'd0, irq_o[0]}, 32'd1);
        @(negedge clk);
        spr_access_i = 1'b1; spr_we_i = 1'b1; spr_addr_i = 16'd0; spr_dat_i = 32'h2000_0002;
        sb_q.push_back('{is_read: 1'b0, addr: 16'd0, exp: 32'd0});
        @(negedge clk);
        check("ip_ack_cycle", {31'd0, spr_ttmr_o[28]}, 32'd0);
        check("irq_ack_cycle", {31'd0, irq_o[0]}, 32'd0);
        spr_access_i = 1'b0; spr_we_i = 1'b0;
        @(negedge clk);
        check("ip_reset", {31'd0, spr_ttmr_o[28]}, 32'd1);
        check("irq_reset", {31'd0, irq_o[0]}, 32'd1);
        rd(16'd0, 32'h3000_0002);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
